// File: rtl/result_byte_packer.sv
// result_byte_packer
//   Packs a non-stallable 8-bit result stream little-endian into 64-bit
//   AXI-Stream beats. A word FIFO (first-word-fall-through) decouples the
//   producer from the back-pressured master side. Partial words are flushed
//   on s_tlast with a matching tkeep. Words pushed into a full FIFO are
//   dropped and flagged on the sticky overflow output.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tlast   input byte stream (no ready; always accepted)
//   m_tdata/m_tkeep/m_tlast/m_tvalid/m_tready   64-bit output stream
//   overflow            sticky, set when a word was dropped
//   fifo_level          number of words currently held
//   drop_cnt            saturating dropped-word counter
//                       (present only when RESULT_BYTE_PACKER_DROP_CNT_EN is defined)
//
// Parameters
//   FIFO_DEPTH          word capacity, power of two, >= 2
//
// Storage: the FIFO head lives in an output register so every output is a
// flop; the remaining words sit in a small array behind it. The total count
// (output register + array) never exceeds FIFO_DEPTH.

module result_byte_packer #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [7:0]                    s_tdata,
    input  logic                          s_tvalid,
    input  logic                          s_tlast,
    output logic [63:0]                   m_tdata,
    output logic [7:0]                    m_tkeep,
    output logic                          m_tlast,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          overflow,
`ifdef RESULT_BYTE_PACKER_DROP_CNT_EN
    output logic [15:0]                   drop_cnt,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    // Packer state
    logic [2:0]  idx_q, idx_d;
    logic [63:0] acc_q, acc_d;

    // FIFO state
    beat_t              out_q, out_d;
    logic               out_valid_q, out_valid_d;
    beat_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               overflow_q, overflow_d;
`ifdef RESULT_BYTE_PACKER_DROP_CNT_EN
    logic [15:0]        drop_cnt_q, drop_cnt_d;
`endif

    // Combinational helpers
    beat_t              word_c;
    logic [63:0]        merged_c;
    logic               push_c;
    logic               pop_c;
    logic               full_c;
    logic               push_ok_c;
    logic               drop_c;
    logic [LVL_W-1:0]   mem_cnt_c;
    logic               mem_we_c;

    // Word assembly: merge current byte, zero bytes above idx, build keep
    always_comb begin
        merged_c = acc_q;
        merged_c[8*idx_q +: 8] = s_tdata;
        word_c.keep = '0;
        for (int k = 0; k < 8; k++) begin
            word_c.keep[k] = (3'(k) <= idx_q);
        end
        word_c.data = merged_c;
        for (int k = 0; k < 8; k++) begin
            if (!word_c.keep[k]) begin
                word_c.data[8*k +: 8] = 8'h00;
            end
        end
        word_c.last = s_tlast;
        push_c = s_tvalid & ((idx_q == 3'd7) | s_tlast);
    end

    // Packer next state
    always_comb begin
        idx_d = idx_q;
        acc_d = acc_q;
        if (s_tvalid) begin
            if (push_c) begin
                idx_d = 3'd0;
                acc_d = '0;
            end else begin
                idx_d = idx_q + 3'd1;
                acc_d = merged_c;
            end
        end
    end

    // FIFO control: a push into a full FIFO is still accepted when a pop
    // frees a slot on the same edge
    always_comb begin
        pop_c     = out_valid_q & m_tready;
        full_c    = (level_q == LVL_W'(FIFO_DEPTH));
        push_ok_c = push_c & (~full_c | pop_c);
        drop_c    = push_c & ~push_ok_c;
        mem_cnt_c = level_q - LVL_W'(out_valid_q);

        out_d       = out_q;
        out_valid_d = out_valid_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        mem_we_c    = 1'b0;

        if (!out_valid_q || pop_c) begin
            // Output register is free for the next cycle: refill from the
            // array first to keep order, else bypass the new word straight in
            if (mem_cnt_c != '0) begin
                out_d       = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                mem_we_c    = push_ok_c;
            end else if (push_ok_c) begin
                out_d       = word_c;
                out_valid_d = 1'b1;
            end else begin
                out_d       = '0;
                out_valid_d = 1'b0;
            end
        end else begin
            mem_we_c = push_ok_c;
        end

        if (mem_we_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        level_d = level_q;
        case ({push_ok_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        overflow_d = overflow_q | drop_c;
    end

`ifdef RESULT_BYTE_PACKER_DROP_CNT_EN
    // Saturating drop counter
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_c && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end
`endif

    // State registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            idx_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef RESULT_BYTE_PACKER_DROP_CNT_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    // Word storage behind the output register; contents are only read
    // after being written, so no reset is needed
    always_ff @(posedge aclk) begin
        if (mem_we_c) begin
            mem_q[wr_ptr_q] <= word_c;
        end
    end

    assign m_tdata    = out_q.data;
    assign m_tkeep    = out_q.keep;
    assign m_tlast    = out_q.last;
    assign m_tvalid   = out_valid_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_result_byte_packer.sv
// Directed testbench for result_byte_packer (FIFO_DEPTH = 4) with a
// scoreboard of expected output beats.
module tb_result_byte_packer;

    localparam int unsigned DEPTH = 4;

    logic        aclk;
    logic        areset;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        overflow;
    logic [2:0]  fifo_level;
`ifdef RESULT_BYTE_PACKER_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    result_byte_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .overflow   (overflow),
`ifdef RESULT_BYTE_PACKER_DROP_CNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .fifo_level (fifo_level)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pops   = 0;
    logic [2:0]  b_idx    = '0;
    logic [63:0] b_acc    = '0;
    bit          drop_next = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: compares every accepted beat with the scoreboard head
    always @(negedge aclk) begin
        if (areset === 1'b0 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_beat: observed data 0x%0h expected no beat", m_tdata);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("beat_data", m_tdata, e.data);
                check("beat_keep", 64'(m_tkeep), 64'(e.keep));
                check("beat_last", 64'(m_tlast), 64'(e.last));
                n_pops++;
            end
        end
    end

    // Drive one byte for one cycle and update the reference packer
    task automatic send_byte(input logic [7:0] d, input logic last);
        exp_t e;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        b_acc[8*b_idx +: 8] = d;
        if (b_idx == 3'd7 || last) begin
            e.data = b_acc;
            e.keep = '0;
            for (int k = 0; k < 8; k++) e.keep[k] = (k <= int'(b_idx));
            e.last = last;
            if (!drop_next) exp_q.push_back(e);
            drop_next = 1'b0;
            b_idx = '0;
            b_acc = '0;
        end else begin
            b_idx = b_idx + 3'd1;
        end
        @(posedge aclk); #2;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge aclk); #2; end
    endtask

    task automatic do_reset();
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge aclk); #2;
        areset = 1'b0;
        b_idx = '0;
        b_acc = '0;
        drop_next = 1'b0;
        exp_q.delete();
    endtask

    // Accept everything until the scoreboard and the DUT are both empty
    task automatic drain(input string tag);
        int t;
        t = 0;
        m_tready = 1'b1;
        while ((exp_q.size() != 0 || m_tvalid === 1'b1) && t < 200) begin
            @(posedge aclk); #2;
            t++;
        end
        n_checks++;
        assert (t < 200) else begin
            n_errors++;
            $error("FAIL %s_timeout: observed %0d pending expected 0", tag, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        areset   = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        @(posedge aclk); #2;
        @(posedge aclk); #2;
        areset = 1'b0;

        // Reset values
        check("rst_tvalid",   64'(m_tvalid),   64'd0);
        check("rst_tdata",    m_tdata,         64'd0);
        check("rst_tkeep",    64'(m_tkeep),    64'd0);
        check("rst_tlast",    64'(m_tlast),    64'd0);
        check("rst_overflow", 64'(overflow),   64'd0);
        check("rst_level",    64'(fifo_level), 64'd0);
`ifdef RESULT_BYTE_PACKER_DROP_CNT_EN
        check("rst_drop_cnt", 64'(drop_cnt),   64'd0);
`endif

        // Full word, back-to-back, visible right after the 8th byte
        m_tready = 1'b1;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        check("full_word_valid", 64'(m_tvalid), 64'd1);
        check("full_word_data",  m_tdata,       64'h0807060504030201);
        drain("full_word");

        // Short packet with gaps
        send_byte(8'hAA, 1'b0);
        idle(2);
        send_byte(8'hBB, 1'b0);
        idle(1);
        send_byte(8'hCC, 1'b1);
        check("short_keep", 64'(m_tkeep), 64'h07);
        check("short_data", m_tdata,      64'h0000000000CCBBAA);
        drain("short");

        // 20 bytes with output stalled, then drain
        m_tready = 1'b0;
        for (int i = 1; i <= 20; i++) send_byte(8'(i), i == 20);
        check("stall_level",  64'(fifo_level), 64'd3);
        check("stall_tvalid", 64'(m_tvalid),   64'd1);
        idle(3);
        check("stall_hold_data", m_tdata,       64'h0807060504030201);
        check("stall_hold_keep", 64'(m_tkeep),  64'hFF);
        p0 = n_pops;
        drain("stall");
        check("stall_beats", 64'(n_pops - p0), 64'd3);
        check("stall_level_end", 64'(fifo_level), 64'd0);

        // Fill FIFO to capacity
        m_tready = 1'b0;
        for (int i = 0; i < 32; i++) send_byte(8'(8'h21 + i), 1'b0);
        check("fill_level",    64'(fifo_level), 64'd4);
        check("fill_overflow", 64'(overflow),   64'd0);

        // Full FIFO, pop coincides with push: no drop
        for (int i = 0; i < 7; i++) send_byte(8'(8'h41 + i), 1'b0);
        m_tready = 1'b1;
        send_byte(8'h48, 1'b0);
        m_tready = 1'b0;
        check("simul_level",    64'(fifo_level), 64'd4);
        check("simul_overflow", 64'(overflow),   64'd0);

        // Full FIFO, no pop: the whole word (including tlast) is dropped
        for (int i = 0; i < 7; i++) send_byte(8'(8'h51 + i), 1'b0);
        check("pre_drop_overflow", 64'(overflow), 64'd0);
        drop_next = 1'b1;
        send_byte(8'h58, 1'b1);
        check("drop_overflow", 64'(overflow),   64'd1);
        check("drop_level",    64'(fifo_level), 64'd4);
`ifdef RESULT_BYTE_PACKER_DROP_CNT_EN
        check("drop_cnt", 64'(drop_cnt), 64'd1);
`endif
        p0 = n_pops;
        drain("overflow");
        check("overflow_beats",  64'(n_pops - p0), 64'd4);
        check("overflow_sticky", 64'(overflow),    64'd1);

        // Reset in the middle of a packet
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h61 + i), 1'b0);
        do_reset();
        check("mid_rst_overflow", 64'(overflow),   64'd0);
        check("mid_rst_level",    64'(fifo_level), 64'd0);
        check("mid_rst_tvalid",   64'(m_tvalid),   64'd0);
        p0 = n_pops;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), i == 7);
        check("post_rst_data", m_tdata, 64'h1716151413121110);
        drain("post_rst");
        check("post_rst_beats", 64'(n_pops - p0), 64'd1);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
